// File: rtl/regfile_np_pkg.sv
// regfile_np_pkg: address helpers shared by the register file and its read ports
package regfile_np_pkg;
`include "regfile_np_defs.vh"
    function automatic logic addr_ok(input int a, input int depth, input logic zr);
        return a < depth && !(zr && a == 0);
    endfunction
endpackage

// File: rtl/regfile_np_defs.vh
// regfile_np_defs: clog2 helper and packed-lane slicing macro shared by the regfile_np files
`ifndef REGFILE_NP_DEFS_VH
`define REGFILE_NP_DEFS_VH
`define RF_LANE(v, i, w) v[(i)*(w) +: (w)]
function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
endfunction
`endif

// File: rtl/regfile_np_rdport.sv
// regfile_np_rdport: one read lane with zero-register, range, bypass and priority selection
`include "regfile_np_defs.vh"
module regfile_np_rdport
    import regfile_np_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH = 32,
    parameter int NWR = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS = 1,
    parameter int AW = 5
) (
    input  logic                  rst,
    input  logic [AW-1:0]         ra,
    input  logic [DATA_W-1:0]     mem [DEPTH],
    input  logic [DEPTH-1:0]      vld,
    input  logic [NWR-1:0]        wok,
    input  logic [NWR*AW-1:0]     wa,
    input  logic [NWR*DATA_W-1:0] wd,
    output logic [DATA_W-1:0]     rd,
    output logic                  rd_valid
);
    // stored value, then forwarded writes in ascending order (last wins), then the hardwired zero entry
    always_comb begin
        rd = '0;
        rd_valid = 1'b0;
        if (addr_ok(int'(ra), DEPTH, 1'b0)) begin
            rd = mem[ra];
            rd_valid = vld[ra];
        end
        if (BYPASS != 0 && !rst) begin
            for (int k = 0; k < NWR; k++) begin
                if (wok[k] && `RF_LANE(wa, k, AW) == ra) begin
                    rd = `RF_LANE(wd, k, DATA_W);
                    rd_valid = 1'b1;
                end
            end
        end
        if (ZERO_REG != 0 && ra == '0) begin
            rd = '0;
            rd_valid = 1'b1;
        end
    end
endmodule

// File: rtl/regfile_np.sv
// regfile_np: NWR-write / NRD-read register file with written-since-reset flags and optional bypass
`include "regfile_np_defs.vh"
module regfile_np
    import regfile_np_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH = 32,
    parameter int NWR = 2,
    parameter int NRD = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS = 1,
    localparam int AW = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NWR-1:0]        we,
    input  logic [NWR*AW-1:0]     wa,
    input  logic [NWR*DATA_W-1:0] wd,
    input  logic [NRD*AW-1:0]     ra,
    output logic [NRD*DATA_W-1:0] rd,
    output logic [NRD-1:0]        rd_valid
);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  vld;
    logic [AW-1:0]     wa_l [NWR];
    logic [NWR-1:0]    wok;

    // a write lands only when enabled, in range and not aimed at the hardwired zero entry
    always_comb begin
        for (int k = 0; k < NWR; k++) begin
            wa_l[k] = `RF_LANE(wa, k, AW);
            wok[k] = we[k] && addr_ok(int'(wa_l[k]), DEPTH, ZERO_REG != 0);
        end
    end

    // storage update; ascending port order lets the highest-indexed port win a conflict
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            vld <= '0;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wok[k]) begin
                    mem[wa_l[k]] <= `RF_LANE(wd, k, DATA_W);
                    vld[wa_l[k]] <= 1'b1;
                end
            end
        end
    end

    genvar j;
    for (j = 0; j < NRD; j++) begin : g_rd
        regfile_np_rdport #(
            .DATA_W(DATA_W),
            .DEPTH(DEPTH),
            .NWR(NWR),
            .ZERO_REG(ZERO_REG),
            .BYPASS(BYPASS),
            .AW(AW)
        ) u_rd (
            .rst(rst),
            .ra(`RF_LANE(ra, j, AW)),
            .mem(mem),
            .vld(vld),
            .wok(wok),
            .wa(wa),
            .wd(wd),
            .rd(`RF_LANE(rd, j, DATA_W)),
            .rd_valid(rd_valid[j])
        );
    end
endmodule

// File: tb/tb_regfile_np.sv
// tb_regfile_np: directed table, corner sequences and randomized model check for regfile_np
module tb_regfile_np;
    logic tb_clk = 1'b0;
    logic rst;
    logic [1:0]  we_ab;
    logic [9:0]  wa_ab, ra_ab;
    logic [63:0] wd_ab, rd_a, rd_b;
    logic [1:0]  rv_a, rv_b;
    logic [2:0]  we_c;
    logic [11:0] wa_c;
    logic [23:0] wd_c;
    logic [15:0] ra_c;
    logic [31:0] rd_c;
    logic [3:0]  rv_c;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_ab [32];
    logic        v_ab [32];
    logic [7:0]  m_c [12];
    logic        v_c [12];

    always #5 tb_clk = ~tb_clk;

    regfile_np u_a (.clk(tb_clk), .rst(rst), .we(we_ab), .wa(wa_ab), .wd(wd_ab),
                    .ra(ra_ab), .rd(rd_a), .rd_valid(rv_a));
    regfile_np #(.BYPASS(0)) u_b (.clk(tb_clk), .rst(rst), .we(we_ab), .wa(wa_ab), .wd(wd_ab),
                    .ra(ra_ab), .rd(rd_b), .rd_valid(rv_b));
    regfile_np #(.DATA_W(8), .DEPTH(12), .NWR(3), .NRD(4), .ZERO_REG(0), .BYPASS(1)) u_c (
                    .clk(tb_clk), .rst(rst), .we(we_c), .wa(wa_c), .wd(wd_c),
                    .ra(ra_c), .rd(rd_c), .rd_valid(rv_c));

    typedef struct packed {
        logic        r;
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic [4:0]  ra0, ra1;
        logic [31:0] xa0, xa1;
        logic [1:0]  xva;
        logic [31:0] xb0, xb1;
        logic [1:0]  xvb;
    } vec_t;
    vec_t tbl [10];

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic set_ab(input logic r, input logic [1:0] we, input logic [4:0] wa0, input logic [4:0] wa1,
                          input logic [31:0] wd0, input logic [31:0] wd1, input logic [4:0] ra0, input logic [4:0] ra1);
        rst = r;
        we_ab = we;
        wa_ab = {wa1, wa0};
        wd_ab = {wd1, wd0};
        ra_ab = {ra1, ra0};
    endtask

    task automatic chk_ab(input string nm, input logic [31:0] a0, input logic [31:0] a1, input logic [1:0] va,
                          input logic [31:0] b0, input logic [31:0] b1, input logic [1:0] vb);
        cmp({nm, "_rd_byp"}, rd_a, {a1, a0});
        cmp({nm, "_vld_byp"}, 64'(rv_a), 64'(va));
        cmp({nm, "_rd_nobyp"}, rd_b, {b1, b0});
        cmp({nm, "_vld_nobyp"}, 64'(rv_b), 64'(vb));
    endtask

    // reference: per address, the highest enabled port aiming at it supplies the new value
    task automatic commit();
        if (rst) begin
            for (int a = 0; a < 32; a++) begin m_ab[a] = '0; v_ab[a] = 1'b0; end
            for (int a = 0; a < 12; a++) begin m_c[a] = '0; v_c[a] = 1'b0; end
        end else begin
            for (int a = 1; a < 32; a++)
                for (int k = 1; k >= 0; k--)
                    if (we_ab[k] && int'(wa_ab[k*5 +: 5]) == a) begin
                        m_ab[a] = wd_ab[k*32 +: 32]; v_ab[a] = 1'b1; break;
                    end
            for (int a = 0; a < 12; a++)
                for (int k = 2; k >= 0; k--)
                    if (we_c[k] && int'(wa_c[k*4 +: 4]) == a) begin
                        m_c[a] = wd_c[k*8 +: 8]; v_c[a] = 1'b1; break;
                    end
        end
    endtask

    function automatic void exp_lane(input int cfg, input int a, output logic [31:0] d, output logic v);
        int depth = (cfg == 2) ? 12 : 32;
        int nwr = (cfg == 2) ? 3 : 2;
        d = '0;
        v = 1'b0;
        if (cfg != 2 && a == 0) begin v = 1'b1; return; end
        if (a >= depth) return;
        d = (cfg == 2) ? 32'(m_c[a]) : m_ab[a];
        v = (cfg == 2) ? v_c[a] : v_ab[a];
        if (cfg == 1 || rst) return;
        for (int k = nwr - 1; k >= 0; k--) begin
            if (cfg == 2 && we_c[k] && int'(wa_c[k*4 +: 4]) == a) begin d = 32'(wd_c[k*8 +: 8]); v = 1'b1; return; end
            if (cfg == 0 && we_ab[k] && int'(wa_ab[k*5 +: 5]) == a) begin d = wd_ab[k*32 +: 32]; v = 1'b1; return; end
        end
    endfunction

    task automatic check_model();
        logic [31:0] d, gd;
        logic v, gv;
        int a;
        for (int cfg = 0; cfg < 3; cfg++) begin
            for (int j = 0; j < ((cfg == 2) ? 4 : 2); j++) begin
                a = (cfg == 2) ? int'(ra_c[j*4 +: 4]) : int'(ra_ab[j*5 +: 5]);
                exp_lane(cfg, a, d, v);
                gd = (cfg == 0) ? rd_a[j*32 +: 32] : (cfg == 1) ? rd_b[j*32 +: 32] : 32'(rd_c[j*8 +: 8]);
                gv = (cfg == 0) ? rv_a[j] : (cfg == 1) ? rv_b[j] : rv_c[j];
                cmp($sformatf("rand_cfg%0d_rd%0d_addr%0d", cfg, j, a), 64'(gd), 64'(d));
                cmp($sformatf("rand_cfg%0d_vld%0d_addr%0d", cfg, j, a), 64'(gv), 64'(v));
            end
        end
    endtask

    task automatic tick();
        @(posedge tb_clk);
        commit();
        #1;
    endtask

    task automatic chk_c(input string nm, input logic [31:0] d, input logic [3:0] v);
        cmp({nm, "_rd"}, 64'(rd_c), 64'(d));
        cmp({nm, "_vld"}, 64'(rv_c), 64'(v));
    endtask

    initial begin
        logic [31:0] fd [32];
        logic [31:0] e;
        tbl[0] = '{1'b1, 2'b01, 5'd7, 5'd0, 32'h1234, 32'h0, 5'd7, 5'd0, 32'h0, 32'h0, 2'b10, 32'h0, 32'h0, 2'b10};
        tbl[1] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd7, 5'd0, 32'h0, 32'h0, 2'b10, 32'h0, 32'h0, 2'b10};
        tbl[2] = '{1'b0, 2'b11, 5'd5, 5'd5, 32'hAAAA_0000, 32'h0000_5555, 5'd5, 5'd7,
                   32'h0000_5555, 32'h0, 2'b01, 32'h0, 32'h0, 2'b00};
        tbl[3] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd5, 5'd5,
                   32'h0000_5555, 32'h0000_5555, 2'b11, 32'h0000_5555, 32'h0000_5555, 2'b11};
        tbl[4] = '{1'b0, 2'b10, 5'd0, 5'd30, 32'h0, 32'h1, 5'd30, 5'd30, 32'h1, 32'h1, 2'b11, 32'h0, 32'h0, 2'b00};
        tbl[5] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd30, 5'd30, 32'h1, 32'h1, 2'b11, 32'h1, 32'h1, 2'b11};
        tbl[6] = '{1'b0, 2'b01, 5'd0, 5'd0, 32'hDEAD_BEEF, 32'h0, 5'd0, 5'd30, 32'h0, 32'h1, 2'b11, 32'h0, 32'h1, 2'b11};
        tbl[7] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b11, 32'h0, 32'h0, 2'b11};
        tbl[8] = '{1'b0, 2'b11, 5'd9, 5'd0, 32'h11, 32'h22, 5'd9, 5'd0, 32'h11, 32'h0, 2'b11, 32'h0, 32'h0, 2'b10};
        tbl[9] = '{1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd9, 5'd5,
                   32'h11, 32'h0000_5555, 2'b11, 32'h11, 32'h0000_5555, 2'b11};

        set_ab(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        we_c = '0; wa_c = '0; wd_c = '0; ra_c = '0;
        tick();
        tick();

        for (int a = 0; a < 32; a++) begin
            set_ab(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'(a), 5'(a));
            #2;
            chk_ab($sformatf("reset_sweep_addr%0d", a), 32'h0, 32'h0, (a == 0) ? 2'b11 : 2'b00,
                   32'h0, 32'h0, (a == 0) ? 2'b11 : 2'b00);
            tick();
        end

        for (int a = 1; a < 32; a++) begin
            fd[a] = $urandom;
            set_ab(1'b0, 2'b01, 5'(a), 5'd0, fd[a], 32'h0, 5'd0, 5'd0);
            tick();
        end
        for (int a = 0; a < 32; a++) begin
            set_ab(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'(a), 5'(a));
            #2;
            e = (a == 0) ? 32'h0 : fd[a];
            chk_ab($sformatf("fill_addr%0d", a), e, e, 2'b11, e, e, 2'b11);
            tick();
        end

        set_ab(1'b1, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        tick();
        for (int i = 0; i < 10; i++) begin
            set_ab(tbl[i].r, tbl[i].we, tbl[i].wa0, tbl[i].wa1, tbl[i].wd0, tbl[i].wd1, tbl[i].ra0, tbl[i].ra1);
            #2;
            chk_ab($sformatf("tbl%0d", i), tbl[i].xa0, tbl[i].xa1, tbl[i].xva, tbl[i].xb0, tbl[i].xb1, tbl[i].xvb);
            tick();
        end

        set_ab(1'b0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 5'd0, 5'd0);
        we_c = 3'b001; wa_c = {4'd0, 4'd0, 4'd0}; wd_c = 24'h00005A; ra_c = '0;
        #2; chk_c("gen_write_addr0", 32'h5A5A_5A5A, 4'b1111); tick();
        we_c = 3'b001; wa_c = {4'd0, 4'd0, 4'd13}; wd_c = 24'h000077; ra_c = {4'd0, 4'd13, 4'd0, 4'd13};
        #2; chk_c("gen_write_oor", 32'h5A00_5A00, 4'b1010); tick();
        we_c = 3'b000; ra_c = {4'd11, 4'd5, 4'd0, 4'd13};
        #2; chk_c("gen_read_oor", 32'h0000_5A00, 4'b0010); tick();
        we_c = 3'b111; wa_c = {4'd3, 4'd3, 4'd3}; wd_c = 24'h332211; ra_c = {4'd3, 4'd3, 4'd3, 4'd3};
        #2; chk_c("gen_conflict_bypass", 32'h3333_3333, 4'b1111); tick();
        we_c = 3'b000;
        #2; chk_c("gen_conflict_stored", 32'h3333_3333, 4'b1111); tick();

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            we_ab = 2'($urandom);
            wd_ab = {$urandom, $urandom};
            for (int k = 0; k < 2; k++) begin
                wa_ab[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
                ra_ab[k*5 +: 5] = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            end
            we_c = 3'($urandom);
            wd_c = 24'($urandom);
            for (int k = 0; k < 3; k++)
                wa_c[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            for (int k = 0; k < 4; k++)
                ra_c[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
            #2;
            check_model();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
